mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave memory arbiter for the NPC core. The instruction fetch unit (IFU) and the load/store unit (LSU) share a single memory port. The arbiter takes one request at a time from either master, with LSU priority and round-robin fairness, and registers it before forwarding it to the slave. It routes the single response back to the owning master and creates an error response if the slave does not answer within a bounded time. It sits between the IFU/LSU and the memory/bus bridge.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT_CYC`, default 255: maximum number of cycles spent waiting for a slave response. 0 disables the timeout.
- `clk` in 1: clock. Everything is rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `ifu_req_valid`/`ifu_req_ready` in/out 1: IFU request handshake. IFU requests are reads only.
- `ifu_addr` in ADDR_W: IFU fetch address.
- `ifu_resp_valid`/`ifu_resp_ready` out/in 1: IFU response handshake.
- `ifu_rdata` out DATA_W, `ifu_err` out 1: IFU response payload.
- `lsu_req_valid`/`lsu_req_ready` in/out 1: LSU request handshake.
- `lsu_addr` in ADDR_W, `lsu_wen` in 1, `lsu_wdata` in DATA_W, `lsu_wstrb` in DATA_W/8: LSU request payload.
- `lsu_resp_valid`/`lsu_resp_ready` out/in 1: LSU response handshake.
- `lsu_rdata` out DATA_W, `lsu_err` out 1: LSU response payload.
- `mem_req_valid`/`mem_req_ready` out/in 1: slave request handshake.
- `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wstrb` out: registered slave request payload.
- `mem_resp_valid`/`mem_resp_ready` in/out 1: slave response handshake.
- `mem_rdata` in DATA_W, `mem_err` in 1: slave response payload.

## Operation
- **Transactions:** at most one transaction is outstanding. The FSM states are IDLE, REQ, RESP and TOUT.
- **IDLE:**
  - When only one master has `*_req_valid` high, that master wins.
  - When both are valid, the winner is the master that did not win last time (`last_grant`).
  - The winner's `*_req_ready` is 1, combinational in IDLE only. The loser's is 0.
  - On the handshake, the arbiter latches the payload into `mem_*` registers and the owner ID, updates `last_grant`, and moves to REQ.
  - For IFU requests the latched values are `wen=0`, `wdata=0` and `wstrb=0`.
- **REQ:**
  - `mem_req_valid` = 1 and the payload is held stable.
  - On `mem_req_ready` the FSM moves to RESP and the timeout counter clears to 0.
- **RESP:**
  - The owner's `*_resp_valid` = `mem_resp_valid`, its `rdata`/`err` = `mem_rdata`/`mem_err`, and `mem_resp_ready` = the owner's `*_resp_ready`.
  - On the handshake the FSM moves to IDLE.
  - The non-owner's `resp_valid` = 0.
  - The counter increments each cycle without `mem_resp_valid`. When it reaches `TIMEOUT_CYC` (and `TIMEOUT_CYC` ≠ 0) the FSM moves to TOUT.
- **TOUT:**
  - The owner's `resp_valid` = 1 with `err` = 1 and `rdata` = 0.
  - When the owner's `resp_ready` is seen, the FSM moves to IDLE.
- **`mem_resp_ready` outside RESP:** it is 1 in IDLE, REQ and TOUT. Stray or late slave responses are accepted and dropped.
- **Reset values:**
  - FSM = IDLE and `last_grant` = IFU, so LSU wins the first tie.
  - All `*_valid` outputs = 0, and every `*_req_ready` except the IDLE winner's = 0.
  - `mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_wen` = 0 and the counter = 0.
- **Reset mid-transaction:** the in-flight transaction is abandoned with no response to the master. The master must also be reset.

## Timing
- **Request acceptance:**
  - A master handshake in IDLE at cycle N gives `mem_req_valid` = 1 at cycle N+1.
  - The minimum request latency through the arbiter is 1 cycle.
- **Response path:** slave response to master response is combinational, with 0 cycles added.
- **Back-to-back:** the best case is 3 cycles per transaction (IDLE, REQ, RESP each one cycle). A new acceptance can happen in the cycle after the response handshake.
- **Timeout:** with no slave response, the error response appears at the owner exactly `TIMEOUT_CYC` cycles after the RESP entry edge.
- **Simultaneous requests:** with both masters continuously requesting, grants strictly alternate LSU, IFU, LSU, and so on.
- **Stable-request assumption:** a master holding `req_valid` must keep its payload stable until it sees `req_ready`. The arbiter samples the payload only on the handshake.

## Structure
- **Package `mem_arb_pkg`:**
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_TOUT} arb_state_e`.
  - `typedef enum logic {MST_IFU, MST_LSU} arb_mst_e`.
- **Sub-module `arb_rr2`:** a 2-way round-robin picker with inputs `req[1:0]` and `last`, and a one-hot `gnt` output. It is combinational and is reused by later arbiters.
- **Top-level contents:** the FSM, payload registers, owner/`last_grant` registers, timeout counter (width `$clog2(TIMEOUT_CYC+1)`, minimum 1) and response mux.

## Test plan
- **Single LSU write:** `lsu` addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 0xF; slave ready immediately, responds the next cycle. Expected: `mem_req_valid` one cycle after acceptance with the exact payload; `lsu_resp_valid` with `err` = 0; `ifu_resp_valid` stays 0.
- **Tie after reset:** IFU and LSU both request at cycle 0. Expected: LSU granted first; IFU granted at the next IDLE; then alternation over 6 transactions.
- **Slave stalls:** slave holds `mem_req_ready` = 0 for 5 cycles, then 1. Expected: `mem_addr`/`mem_wdata` stable across all 6 cycles.
- **Response backpressure:** IFU holds `ifu_resp_ready` = 0 for 3 cycles. Expected: `mem_resp_ready` = 0 for those cycles; `ifu_rdata` = `mem_rdata` (0x0000_0413) when accepted.
- **Timeout:** `TIMEOUT_CYC` = 4 and the slave never responds. Expected: `lsu_resp_valid` with `err` = 1 and `rdata` = 0 four cycles after RESP entry; a late `mem_resp_valid` in IDLE is dropped and not routed.
- **Reset mid-RESP:** `rst_n` pulsed low asynchronously while in RESP. Expected: all valids 0 immediately; FSM in IDLE; the next tie grants LSU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the NPC memory arbiter: FSM states, master IDs and
// the timeout-counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_TOUT} arb_state_e;
  typedef enum logic {MST_IFU, MST_LSU} arb_mst_e;

  // Counter must hold TIMEOUT_CYC itself; a disabled timeout still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned tmo);
    return (tmo == 0) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the requester that did not win
// last time is granted. Bit 0 / last=0 is requester 0.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU -> single memory port arbiter. One outstanding transaction,
// registered request payload, combinational response path, timeout error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  arb_state_e          state_q, state_d;
  arb_mst_e            owner_q, owner_d;
  arb_mst_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0]          gnt;
  logic                own_lsu;
  logic                own_ready;
  logic                resp_v;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic [CNT_W-1:0]    cnt_inc;

  arb_rr2 u_rr (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_grant_q == MST_LSU),
    .gnt  (gnt)
  );

  assign own_lsu   = (owner_q == MST_LSU);
  assign own_ready = own_lsu ? lsu_resp_ready : ifu_resp_ready;
  assign cnt_inc   = cnt_q + 1'b1;

  // Request side: ready only toward the IDLE winner.
  assign ifu_req_ready = (state_q == ARB_IDLE) && gnt[0];
  assign lsu_req_ready = (state_q == ARB_IDLE) && gnt[1];
  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  // Response side: slave passes straight through in RESP, synthetic error in TOUT.
  always_comb begin
    resp_v         = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_resp_ready = 1'b1;
    unique case (state_q)
      ARB_RESP: begin
        resp_v         = mem_resp_valid;
        resp_rdata     = mem_rdata;
        resp_err       = mem_err;
        mem_resp_ready = own_ready;
      end
      ARB_TOUT: begin
        resp_v   = 1'b1;
        resp_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign ifu_resp_valid = resp_v && !own_lsu;
  assign lsu_resp_valid = resp_v && own_lsu;
  assign ifu_rdata      = resp_rdata;
  assign lsu_rdata      = resp_rdata;
  assign ifu_err        = resp_err;
  assign lsu_err        = resp_err;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt[1]) begin
          owner_d      = MST_LSU;
          last_grant_d = MST_LSU;
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wstrb_d      = lsu_wstrb;
          state_d      = ARB_REQ;
        end else if (gnt[0]) begin
          owner_d      = MST_IFU;
          last_grant_d = MST_IFU;
          addr_d       = ifu_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wstrb_d      = '0;
          state_d      = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) begin
          state_d = ARB_RESP;
          cnt_d   = '0;
        end
      end
      ARB_RESP: begin
        if (mem_resp_valid) begin
          if (own_ready) state_d = ARB_IDLE;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) state_d = ARB_TOUT;
        end
      end
      ARB_TOUT: begin
        if (own_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= MST_IFU;
      last_grant_q <= MST_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven on the falling edge,
// outputs checked 1ns later, state advances on the rising edge.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid, ifu_resp_ready;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_err;
  logic          lsu_req_valid, lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wstrb;
  logic          lsu_resp_valid, lsu_resp_ready;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_resp_valid, mem_resp_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0; mem_err = 0;

    // Reset state
    step(); step(); settle();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_mem_payload", {mem_addr, mem_wdata, mem_wstrb, mem_wen}, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 1);
    rst_n = 1'b1;

    // Single LSU write
    step();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    settle();
    chk("w_lsu_req_ready", lsu_req_ready, 1);
    chk("w_ifu_req_ready", ifu_req_ready, 0);
    step();
    lsu_req_valid = 0; mem_req_ready = 1; settle();
    chk("w_mem_req_valid", mem_req_valid, 1);
    chk("w_mem_addr", mem_addr, 32'h8000_0010);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_mem_wstrb_wen", {mem_wstrb, mem_wen}, {4'hF, 1'b1});
    chk("w_lsu_req_ready_busy", lsu_req_ready, 0);
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678; lsu_resp_ready = 1;
    settle();
    chk("w_lsu_resp_valid", lsu_resp_valid, 1);
    chk("w_lsu_err", lsu_err, 0);
    chk("w_ifu_resp_valid", ifu_resp_valid, 0);
    chk("w_mem_req_valid_resp", mem_req_valid, 0);
    chk("w_mem_resp_ready", mem_resp_ready, 1);
    step();
    mem_resp_valid = 0; settle();
    chk("w_idle_resp_valid", lsu_resp_valid, 0);

    // Tie after reset: LSU first, then strict alternation
    rst_n = 0; step(); rst_n = 1;
    ifu_req_valid = 1; lsu_req_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      logic exp_lsu;
      exp_lsu   = (i % 2 == 0);
      ifu_addr  = 32'h0000_1000 + 32'(i * 4);
      lsu_addr  = 32'h0000_2000 + 32'(i * 4);
      lsu_wen   = 1; lsu_wdata = 32'hA5A5_0000 + 32'(i); lsu_wstrb = 4'h3;
      settle();
      chk("tie_lsu_ready", lsu_req_ready, exp_lsu);
      chk("tie_ifu_ready", ifu_req_ready, !exp_lsu);
      step();
      mem_req_ready = 1; settle();
      chk("tie_mem_addr", mem_addr, exp_lsu ? lsu_addr : ifu_addr);
      chk("tie_mem_wen_wdata_wstrb", {mem_wen, mem_wdata, mem_wstrb},
          exp_lsu ? {1'b1, lsu_wdata, 4'h3} : 37'h0);
      step();
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'(i); settle();
      chk("tie_resp_valid", {lsu_resp_valid, ifu_resp_valid}, exp_lsu ? 2'b10 : 2'b01);
      step();
      mem_resp_valid = 0;
    end
    ifu_req_valid = 0; lsu_req_valid = 0;

    // Slave stalls request for 5 cycles
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
    lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF;
    settle();
    chk("st_lsu_ready", lsu_req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
      mem_req_ready = (k == 5); settle();
      chk("st_mem_req_valid", mem_req_valid, 1);
      chk("st_mem_addr_wdata", {mem_addr, mem_wdata}, {32'h8000_0100, 32'hCAFE_F00D});
    end
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0; settle();
    chk("st_lsu_resp_valid", lsu_resp_valid, 1);
    step();
    mem_resp_valid = 0;

    // IFU response backpressure
    ifu_req_valid = 1; ifu_addr = 32'h0000_3000; ifu_resp_ready = 0; settle();
    chk("bp_ifu_ready", ifu_req_ready, 1);
    step();
    ifu_req_valid = 0; mem_req_ready = 1; settle();
    chk("bp_mem_req", {mem_req_valid, mem_addr}, {1'b1, 32'h0000_3000});
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_ifu_resp_valid", ifu_resp_valid, 1);
      chk("bp_mem_resp_ready", mem_resp_ready, 0);
      step();
    end
    ifu_resp_ready = 1; settle();
    chk("bp_mem_resp_ready_acc", mem_resp_ready, 1);
    chk("bp_ifu_rdata_err", {ifu_rdata, ifu_err}, {32'h0000_0413, 1'b0});
    step();
    mem_resp_valid = 0; settle();
    chk("bp_ifu_resp_done", ifu_resp_valid, 0);

    // Timeout with TIMEOUT_CYC = 4
    lsu_req_valid = 1; lsu_addr = 32'h0000_4000; lsu_wen = 0; lsu_resp_ready = 0;
    step();
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("to_wait_resp_valid", lsu_resp_valid, 0);
      step();
    end
    settle();
    chk("to_lsu_resp", {lsu_resp_valid, lsu_err, lsu_rdata}, {1'b1, 1'b1, 32'h0});
    chk("to_ifu_resp_valid", ifu_resp_valid, 0);
    chk("to_mem_resp_ready", mem_resp_ready, 1);
    step(); settle();
    chk("to_hold", {lsu_resp_valid, lsu_err}, 2'b11);
    lsu_resp_ready = 1;
    step(); settle();
    chk("to_done", lsu_resp_valid, 0);
    mem_resp_valid = 1; mem_rdata = 32'h0000_0BAD; settle();
    chk("to_late_dropped", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 3'b001);
    step();
    mem_resp_valid = 0;

    // Reset asserted mid-RESP
    ifu_req_valid = 1; ifu_addr = 32'h0000_5000; ifu_resp_ready = 0;
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h55; settle();
    chk("rr_pre_resp_valid", ifu_resp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rr_valids_cleared", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
    chk("rr_mem_addr", mem_addr, 0);
    mem_resp_valid = 0;
    step();
    rst_n = 1; ifu_req_valid = 1; lsu_req_valid = 1; settle();
    chk("rr_tie_lsu", {lsu_req_ready, ifu_req_ready}, 2'b10);
    ifu_req_valid = 0; lsu_req_valid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
